// File: rtl/case_3_prod_accum.sv
// Frame accumulator for signed multiplier products: sums FRAME_LEN accepted products and
// emits the frame sum with saturate-or-wrap arithmetic and a sticky per-frame overflow flag.
module case_3_prod_accum #(
  parameter int unsigned DIN_WIDTH = 26,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAME_LEN = 4,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic                 ovf
);

  localparam int unsigned CntWidth = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(FRAME_LEN - 1);
  localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

  typedef enum logic {StAcc, StOut} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 ovf_r_q, ovf_r_d;
  logic [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] din_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 overflow;
  logic [ACC_WIDTH-1:0] result;
  logic                 accept;

  // One guard bit: overflow iff the two top bits of the widened sum disagree.
  always_comb begin
    din_ext  = ACC_WIDTH'($signed(din));
    sum      = {acc_q[ACC_WIDTH-1], acc_q} + {din_ext[ACC_WIDTH-1], din_ext};
    overflow = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    result   = sum[ACC_WIDTH-1:0];
    if (overflow && SATURATE) begin
      result = sum[ACC_WIDTH] ? AccMin : AccMax;
    end
  end

  assign accept = din_vld & (state_q == StAcc);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_r_d = ovf_r_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          if (cnt_q == CntLast) begin
            dout_d  = result;
            ovf_d   = ovf_r_q | overflow;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_r_d = 1'b0;
            state_d = StOut;
          end else begin
            acc_d   = result;
            cnt_d   = cnt_q + 1'b1;
            ovf_r_d = ovf_r_q | overflow;
          end
        end
      end
      StOut: begin
        if (dout_rdy) begin
          state_d = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_r_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_r_q <= ovf_r_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs come from registered state only; din_rdy is also masked by reset.
  assign din_rdy  = (state_q == StAcc) & ~ap_rst;
  assign dout_vld = (state_q == StOut);
  assign dout     = dout_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_case_3_prod_accum.sv
// Bench for case_3_prod_accum: one 32-bit saturating instance and two 26-bit instances
// (saturate and wrap) share stimulus; frame results are checked through an expectation queue.
module tb_case_3_prod_accum;

  logic        ap_clk;
  logic        ap_rst;
  logic [25:0] din;
  logic        din_vld;
  logic        dout_rdy;

  logic        rdy32, rdys, rdyw;
  logic        vld32, vlds, vldw;
  logic        ovf32, ovfs, ovfw;
  logic [31:0] dout32;
  logic [25:0] douts, doutw;

  case_3_prod_accum #(.DIN_WIDTH(26), .ACC_WIDTH(32), .FRAME_LEN(4), .SATURATE(1'b1)) dut32 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din(din), .din_vld(din_vld), .din_rdy(rdy32),
    .dout(dout32), .dout_vld(vld32), .dout_rdy(dout_rdy), .ovf(ovf32)
  );
  case_3_prod_accum #(.DIN_WIDTH(26), .ACC_WIDTH(26), .FRAME_LEN(4), .SATURATE(1'b1)) duts (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din(din), .din_vld(din_vld), .din_rdy(rdys),
    .dout(douts), .dout_vld(vlds), .dout_rdy(dout_rdy), .ovf(ovfs)
  );
  case_3_prod_accum #(.DIN_WIDTH(26), .ACC_WIDTH(26), .FRAME_LEN(4), .SATURATE(1'b0)) dutw (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din(din), .din_vld(din_vld), .din_rdy(rdyw),
    .dout(doutw), .dout_vld(vldw), .dout_rdy(dout_rdy), .ovf(ovfw)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    int d0; int d1; int d2; int d3;
    int e32; bit o32; int es; bit os; int ew; bit ow;
  } vec_t;

  typedef struct packed {
    int v32; bit o32; int vs; bit os; int vw; bit ow;
  } exp_t;

  exp_t expq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
  endtask

  task automatic push_same(input int v, input bit o);
    expq.push_back('{v, o, v, o, v, o});
  endtask

  // Drive one product and hold it until accepted; inputs change 1 time unit after posedge.
  task automatic send(input int v);
    int n;
    din     = 26'(v);
    din_vld = 1'b1;
    n = 0;
    while (!rdy32 && n < 20) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (n >= 20) check("send_timeout", 32'(rdy32), 32'd1);
    @(posedge ap_clk); #1;
    din_vld = 1'b0;
  endtask

  task automatic bubble();
    din_vld = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  // Scoreboard: compare on the cycle the output handshake completes.
  always @(negedge ap_clk) begin
    if (!ap_rst && dout_rdy && (vld32 || vlds || vldw)) begin
      exp_t e;
      if (expq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got dout=%0d with no frame pending at %0t",
                 $signed(dout32), $time);
      end else begin
        e = expq.pop_front();
        check("vld_s", 32'(vlds), 32'd1);
        check("vld_w", 32'(vldw), 32'd1);
        check("dout32", dout32, e.v32);
        check("ovf32", 32'(ovf32), 32'(e.o32));
        check("dout_sat26", $signed(douts), e.vs);
        check("ovf_sat26", 32'(ovfs), 32'(e.os));
        check("dout_wrap26", $signed(doutw), e.vw);
        check("ovf_wrap26", 32'(ovfw), 32'(e.ow));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    tbl[0] = '{33554431, 33554431, 33554431, 33554431, 134217724, 1'b0, 33554431, 1'b1, -4, 1'b1};
    tbl[1] = '{1, 2, 3, 4, 10, 1'b0, 10, 1'b0, 10, 1'b0};
    tbl[2] = '{-33554432, -33554432, -33554432, -33554432,
               -134217728, 1'b0, -33554432, 1'b1, 0, 1'b1};
    tbl[3] = '{33554431, 33554431, -33554432, -1, 33554429, 1'b0, -2, 1'b1, 33554429, 1'b1};
    tbl[4] = '{-33554432, -1, 5, 0, -33554428, 1'b0, -33554427, 1'b1, -33554428, 1'b1};

    ap_rst   = 1'b1;
    din      = '0;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    #2;
    check("rst_din_rdy", 32'(rdy32), 32'd0);
    check("rst_dout_vld", 32'(vld32), 32'd0);
    check("rst_dout", dout32, 32'd0);
    check("rst_ovf", 32'(ovf32), 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    check("post_rst_din_rdy", 32'(rdy32), 32'd1);

    // Basic frame, then hold the result under backpressure.
    dout_rdy = 1'b0;
    push_same(15, 1'b0);
    send(3); send(-5); send(7); send(10);
    check("latency_dout_vld", 32'(vld32), 32'd1);
    check("out_din_rdy", 32'(rdy32), 32'd0);
    for (int i = 0; i < 5; i++) begin
      din     = 26'd99;
      din_vld = 1'b1;
      @(posedge ap_clk); #1;
      check("bp_dout_vld", 32'(vld32), 32'd1);
      check("bp_dout", dout32, 32'd15);
      check("bp_din_rdy", 32'(rdy32), 32'd0);
    end
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    @(posedge ap_clk); #1;
    check("release_dout_vld", 32'(vld32), 32'd0);
    check("release_din_rdy", 32'(rdy32), 32'd1);
    check("retain_dout", dout32, 32'd15);

    push_same(4, 1'b0);
    send(1); send(1); send(1); send(1);

    for (int i = 0; i < 5; i++) begin
      expq.push_back('{tbl[i].e32, tbl[i].o32, tbl[i].es, tbl[i].os, tbl[i].ew, tbl[i].ow});
      send(tbl[i].d0); send(tbl[i].d1); send(tbl[i].d2); send(tbl[i].d3);
    end
    @(posedge ap_clk); #1;

    // Reset mid-frame discards the partial sum; bubbles must not advance the count.
    send(100); send(200);
    #3;
    ap_rst = 1'b1;
    #1;
    check("midrst_dout", dout32, 32'd0);
    check("midrst_dout_vld", 32'(vld32), 32'd0);
    check("midrst_din_rdy", 32'(rdy32), 32'd0);
    check("midrst_ovf", 32'(ovfw), 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    push_same(4, 1'b0);
    send(1); bubble(); send(1); send(1); bubble(); send(1);

    repeat (3) @(posedge ap_clk);
    #1;
    check("queue_drained", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
